// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizes, the complex sample type and the
// commutator state encoding.
package fft_pkg;

  localparam int DW = 12;          // signed width of each real/imag component
  localparam int N  = 64;          // frame length (power of 2, >= 8)
  localparam int Q  = N / 4;       // number of radix-4 groups per frame
  localparam int NW = $clog2(N);   // write counter width
  localparam int QW = $clog2(Q);   // read counter / group index width

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/radix4_input_commutator_if.sv
// Handshake bundle of the radix-4 input commutator: a serial sample input
// and a four-operand group output. slave = commutator side, master = the
// source/sink around it.
interface radix4_input_commutator_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] r_g0;
  logic signed [DW-1:0] i_g0;
  logic signed [DW-1:0] r_g1;
  logic signed [DW-1:0] i_g1;
  logic signed [DW-1:0] r_g2;
  logic signed [DW-1:0] i_g2;
  logic signed [DW-1:0] r_g3;
  logic signed [DW-1:0] i_g3;
  logic [QW-1:0]        out_idx;
  logic                 frame_done;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid,
    output r_g0, i_g0, r_g1, i_g1, r_g2, i_g2, r_g3, i_g3,
    output out_idx, frame_done
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid,
    input  r_g0, i_g0, r_g1, i_g1, r_g2, i_g2, r_g3, i_g3,
    input  out_idx, frame_done
  );

endinterface

// File: rtl/radix4_input_commutator.sv
// Radix-4 input commutator: buffers one frame of N serial complex samples,
// then presents x[n], x[n+Q], x[n+2Q], x[n+3Q] for n = 0..Q-1 to the first
// radix-4 butterfly. Samples pass bit-exact.
module radix4_input_commutator
  import fft_pkg::*;
(
  input logic                          clk,
  input logic                          rst_n,
  radix4_input_commutator_if.slave     bus
);

  state_t        state;
  logic [NW-1:0] wr_cnt;
  logic [QW-1:0] rd_cnt;
  logic          frame_done_q;
  cplx_t         mem [N];
  cplx_t         grp [4];

  logic in_fire;
  logic out_fire;

  assign in_fire  = (state == FILL)  && bus.in_valid;
  assign out_fire = (state == DRAIN) && bus.out_ready;

  // Control: fill/drain sequencing, counters and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state        <= FILL;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        FILL: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;          // wraps to 0 after N-1
            if (wr_cnt == NW'(N - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;          // wraps to 0 after Q-1
            if (rd_cnt == QW'(Q - 1)) begin
              state        <= FILL;
              frame_done_q <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Sample storage: written only while filling.
  always_ff @(posedge clk) begin
    // NOTE: the sample array has no reset; the control reset alone guarantees
    // nothing stale is ever presented, and a reset here would only cost logic.
    if (in_fire) mem[wr_cnt] <= '{re: bus.in_re, im: bus.in_im};
  end

  // Group read: the four operands sit at rd_cnt + k*Q, i.e. {k, rd_cnt}.
  always_comb begin
    for (int k = 0; k < 4; k++) grp[k] = mem[{2'(k), rd_cnt}];
  end

  assign bus.in_ready   = (state == FILL);
  assign bus.out_valid  = (state == DRAIN);
  assign bus.out_idx    = (state == DRAIN) ? rd_cnt : '0;
  assign bus.frame_done = frame_done_q;

  assign bus.r_g0 = grp[0].re;
  assign bus.i_g0 = grp[0].im;
  assign bus.r_g1 = grp[1].re;
  assign bus.i_g1 = grp[1].im;
  assign bus.r_g2 = grp[2].re;
  assign bus.i_g2 = grp[2].im;
  assign bus.r_g3 = grp[3].re;
  assign bus.i_g3 = grp[3].im;

endmodule

// File: tb/tb_radix4_input_commutator.sv
// Self-checking bench for radix4_input_commutator. A frame-level reference
// model collects accepted samples into a frame and, once full, expects
// group n to be samples n, n+Q, n+2Q, n+3Q of that frame.
module tb_radix4_input_commutator;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  radix4_input_commutator_if bus ();

  radix4_input_commutator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  q_re[$];
  int  q_im[$];
  int  e_re[N];
  int  e_im[N];
  bit  m_drain  = 0;
  bit  m_fd     = 0;
  int  m_grp    = 0;
  int  m_frames = 0;
  int  fd_seen  = 0;
  bit  en       = 0;

  // Compare outputs against the model, then advance the model with the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (en) begin
      check("in_ready",   bus.in_ready,   !m_drain);
      check("out_valid",  bus.out_valid,  m_drain);
      check("frame_done", bus.frame_done, m_fd);
      if (bus.frame_done) fd_seen++;
      if (m_drain) begin
        check("out_idx", bus.out_idx, m_grp);
        check("r_g0", bus.r_g0, e_re[m_grp]);
        check("i_g0", bus.i_g0, e_im[m_grp]);
        check("r_g1", bus.r_g1, e_re[m_grp + Q]);
        check("i_g1", bus.i_g1, e_im[m_grp + Q]);
        check("r_g2", bus.r_g2, e_re[m_grp + 2*Q]);
        check("i_g2", bus.i_g2, e_im[m_grp + 2*Q]);
        check("r_g3", bus.r_g3, e_re[m_grp + 3*Q]);
        check("i_g3", bus.i_g3, e_im[m_grp + 3*Q]);
      end else begin
        check("out_idx_idle", bus.out_idx, 0);
      end
    end
    m_fd = 0;
    if (!rst_n) begin
      m_drain = 0;
      m_grp   = 0;
      q_re.delete();
      q_im.delete();
      en = 1;
    end else if (!m_drain) begin
      if (bus.in_valid) begin
        q_re.push_back(int'(bus.in_re));
        q_im.push_back(int'(bus.in_im));
        if (q_re.size() == N) begin
          for (int i = 0; i < N; i++) begin
            e_re[i] = q_re[i];
            e_im[i] = q_im[i];
          end
          q_re.delete();
          q_im.delete();
          m_drain = 1;
        end
      end
    end else if (bus.out_ready) begin
      m_grp++;
      if (m_grp == Q) begin
        m_grp   = 0;
        m_drain = 0;
        m_fd    = 1;
        m_frames++;
      end
    end
  end

  // ---------------- out_ready pattern ----------------
  int or_mode = 0;   // 0: always 1, 1: 1,0,0 repeating, 2: random
  int or_cnt  = 0;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      1:       bus.out_ready = (or_cnt % 3 == 0);
      2:       bus.out_ready = 1'($urandom_range(1));
      default: bus.out_ready = 1'b1;
    endcase
    or_cnt++;
  end

  // ---------------- stimulus tasks (return at posedge + 1) ----------------
  bit first_fd;

  task automatic send_sample(input int re, input int im, output bit fd_at_accept);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_re    = DW'(re);
    bus.in_im    = DW'(im);
    acc = 0;
    fd_at_accept = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc          = bus.in_ready;
      fd_at_accept = bus.frame_done;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  // kind 0: ramp (k, -k); 1: sign extremes; 2: random
  task automatic send_frame(input int kind, input int gap_pct, input int nsamp);
    int re, im;
    bit fd;
    for (int k = 0; k < nsamp; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      case (kind)
        0: begin re = k; im = -k; end
        1: begin
          re = (k % 2 == 0) ? -2048 : 2047;
          im = (k % 2 == 0) ? 2047 : -2048;
        end
        default: begin
          re = int'($urandom_range(4095)) - 2048;
          im = int'($urandom_range(4095)) - 2048;
        end
      endcase
      send_sample(re, im, fd);
      if (k == 0) first_fd = fd;
    end
  endtask

  task automatic wait_frame_done(input int limit);
    bit found = 0;
    for (int t = 0; t < limit && !found; t++) begin
      @(posedge clk);
      #1;
      found = bus.frame_done;
    end
    if (!found) check("frame_done_timeout", 0, 1);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp, no stalls.
    or_mode = 0;
    send_frame(0, 0, N);
    wait_frame_done(100);

    // Backpressure during drain.
    or_mode = 1;
    send_frame(0, 0, N);
    wait_frame_done(200);

    // Input gaps, then 0x7FF offered during drain must be ignored.
    or_mode = 0;
    send_frame(0, 50, N);
    bus.in_valid = 1'b1;
    bus.in_re    = 12'sh7FF;
    bus.in_im    = 12'sh7FF;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_frame_done(100);

    // Sign extremes with random backpressure.
    or_mode = 2;
    send_frame(1, 0, N);
    wait_frame_done(400);

    // Reset mid-FILL at wr_cnt = 30, then a fresh frame.
    or_mode = 0;
    send_frame(2, 0, 30);
    pulse_reset(1);
    send_frame(2, 20, N);
    wait_frame_done(100);

    // Reset mid-DRAIN at rd_cnt = 5, then a fresh frame.
    send_frame(0, 0, N);
    repeat (5) @(posedge clk);
    #1;
    pulse_reset(1);
    send_frame(2, 0, N);
    wait_frame_done(100);

    // Back-to-back frames A and B with no idle cycles.
    send_frame(2, 0, N);
    send_frame(2, 0, N);
    check("b2b_fill_starts_on_frame_done", first_fd, 1);
    wait_frame_done(100);

    repeat (5) @(posedge clk);
    #1;
    check("frames_completed_model", m_frames, 8);
    check("frame_done_pulses", fd_seen, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/radix4_input_commutator.md
Name: radix4_input_commutator

Overview:
- Collects one frame of N serial complex samples, then presents them four at a time to the radix-4 stage: x[n], x[n+N/4], x[n+N/2], x[n+3N/4] for n = 0..N/4-1.
- It is the distribution end of the four-input complex summing path: it splits a serial stream into the g0..g3 operand sets that the summing adder combines.
- It sits between the sample source and the first radix-4 butterfly of the 64-point FFT.

Parameters:
- DW, 12, signed width of each real/imag component.
- N, 64, frame length. Must be a power of 2 and at least 8. Q = N/4 is the number of groups.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_re  input  DW  input sample real part, signed.
- in_im  input  DW  input sample imag part, signed.
- out_valid  output  1  output group valid.
- out_ready  input  1  downstream accepts the group.
- r_g0, i_g0  output  DW  x[n], real and imag.
- r_g1, i_g1  output  DW  x[n+Q], real and imag.
- r_g2, i_g2  output  DW  x[n+2Q], real and imag.
- r_g3, i_g3  output  DW  x[n+3Q], real and imag.
- out_idx  output  log2(Q)  group index n of the presented group.
- frame_done  output  1  one-cycle pulse after the last group is accepted.

Behaviour:
- Storage: N x 2·DW register array. The array is not reset.
- Counters: wr_cnt, log2(N) bits; rd_cnt, log2(Q) bits.
- States: FILL and DRAIN, held in a state register.
- Reset, applied when rst_n=0 at a clk edge:
  - state=FILL, wr_cnt=0, rd_cnt=0.
  - out_valid=0, frame_done=0, in_ready=1 from the following cycle.
  - Reset mid-FILL or mid-DRAIN discards the partial frame. No groups are emitted from stale data.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, sample {in_re,in_im} is written to mem[wr_cnt] and wr_cnt increments.
  - Gaps in in_valid are allowed; nothing changes on idle cycles.
  - The handshake at wr_cnt=N-1 wraps wr_cnt to 0 and moves to DRAIN on the next edge.
- DRAIN:
  - in_ready=0. in_valid is ignored and no writes occur.
  - out_valid=1 starting the cycle after the N-th input handshake. This is the fill-to-first-output latency of 1 cycle.
  - g0..g3 are read combinationally from mem[rd_cnt + k·Q], k = 0..3. out_idx=rd_cnt.
  - Data and out_idx stay stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, rd_cnt increments.
  - The handshake at rd_cnt=Q-1 wraps rd_cnt to 0, returns to FILL, and asserts frame_done=1 for exactly the next cycle. in_ready=1 in that same cycle.
- Throughput: one group per cycle when out_ready is held high. A full frame takes N input cycles plus Q output cycles, with no bubble between DRAIN and the next FILL.
- Outputs while out_valid=0: out_idx=0. g0..g3 are don't-care and must not be checked.
- Arithmetic: none. Samples pass bit-exact, sign preserved.
- Simultaneous events: rst_n=0 overrides any handshake in the same cycle.
- Out-of-range: not possible. Counters wrap exactly at N-1 and Q-1.

Decomposition:
- Shared FFT package (fft_pkg):
  - DW, N, Q, and the derived widths log2(N) and log2(Q).
  - The complex sample type: a packed struct of signed re and im fields, each DW bits.
  - The state enum {FILL, DRAIN}.
- No sub-module is needed. The storage array stays inline, because a 4-read-port register file does not map cleanly to a generic RAM.

Test Plan:
- Ramp, no stalls: in_re=k, in_im=-k for k = 0..63, out_ready=1.
  - 16 groups on consecutive cycles, first one cycle after the 64th handshake.
  - Group n has r_g0..r_g3 = n, n+16, n+32, n+48 and the i_g values are their negations.
  - frame_done pulses once.
- Backpressure: out_ready toggles 1,0,0,1,... during DRAIN.
  - Outputs and out_idx are held during stalls.
  - Exactly 16 unique groups, in order. in_ready stays 0 throughout DRAIN.
- Input gaps: in_valid random at 50% duty.
  - Output matches the ramp case.
  - Input attempted during DRAIN is not written: sending 0x7FF during DRAIN leaves the next frame uncorrupted.
- Sign extremes: samples alternate 0x800 (-2048) and 0x7FF (+2047).
  - Output values are bit-exact, e.g. group 0 r_g0=-2048.
- Reset mid-FILL at wr_cnt=30, then reset mid-DRAIN at rd_cnt=5.
  - Each time: out_valid=0 next cycle and in_ready=1.
  - A fresh 64-sample frame then drains correctly from out_idx=0.
- Back-to-back frames A and B with no idle cycles.
  - FILL of B starts the cycle frame_done pulses for A.
  - B's groups contain only B data.
